// File: rtl/flush_collector.sv
// flush_collector: grants flush to one of two scanners, counts the units each drains into an
// occupancy-tracked buffer, and hands them downstream. Define FLUSH_COLLECTOR_WAKE_EN for stby wake pulses.
module flush_collector #(
  parameter int DEPTH   = 512,
  parameter int CNT_W   = 10,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rdy_flush_a,
  input  logic             rdy_flush_b,
  input  logic [2:0]       state_a,
  input  logic [2:0]       state_b,
  input  logic [7:0]       mem_used_a,
  input  logic [7:0]       mem_used_b,
  output logic             flush_a,
  output logic             flush_b,
  output logic             goto_stby_a,
  output logic             goto_stby_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] occupancy,
  output logic             busy,
  output logic             err_timeout,
  output logic             err_mismatch,
  output logic             overflow
);
  localparam logic [2:0] ST_IDLE     = 3'b011;
  localparam logic [2:0] ST_FLUSHING = 3'b100;
  localparam int         TMO_W       = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT, RECV} fsm_t;
  typedef enum logic {SEL_A = 1'b0, SEL_B = 1'b1} sel_t;

  fsm_t             fsm;
  sel_t             sel;
  sel_t             last_served;
  sel_t             pick;
  logic [7:0]       expected;
  logic [8:0]       recv;
  logic [TMO_W-1:0] tmo;

  logic [CNT_W:0]   free;
  logic             req_a, req_b, elig_a, elig_b;
  logic [2:0]       state_sel;
  logic [7:0]       mem_sel;
  logic             flushing_sel, unit_in, accept, recv_done;

  assign free   = (CNT_W+1)'(DEPTH) - {1'b0, occupancy};
  assign req_a  = rdy_flush_a | (state_a == ST_IDLE);
  assign req_b  = rdy_flush_b | (state_b == ST_IDLE);
  assign elig_a = req_a & (free >= (CNT_W+1)'(mem_used_a));
  assign elig_b = req_b & (free >= (CNT_W+1)'(mem_used_b));

  // Round-robin on a tie; otherwise whichever scanner is eligible.
  assign pick = (elig_a && elig_b) ? ((last_served == SEL_A) ? SEL_B : SEL_A)
                                   : (elig_a ? SEL_A : SEL_B);

  assign state_sel    = (sel == SEL_A) ? state_a : state_b;
  assign mem_sel      = (sel == SEL_A) ? mem_used_a : mem_used_b;
  assign flushing_sel = (state_sel == ST_FLUSHING);

  // The cycle in which WAIT first observes flushing already carries the first unit.
  assign unit_in   = ((fsm == WAIT) || (fsm == RECV)) && flushing_sel && (mem_sel != 8'd0);
  assign accept    = out_valid & out_ready;
  assign recv_done = (fsm == RECV) && !flushing_sel;
  assign out_valid = (occupancy != '0);
  assign busy      = (fsm != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every branch reads pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm          <= IDLE;
      sel          <= SEL_A;
      last_served  <= SEL_B;
      expected     <= '0;
      recv         <= '0;
      tmo          <= '0;
      flush_a      <= 1'b0;
      flush_b      <= 1'b0;
      err_timeout  <= 1'b0;
      err_mismatch <= 1'b0;
    end else begin
      flush_a     <= 1'b0;
      flush_b     <= 1'b0;
      err_timeout <= 1'b0;
      if (unit_in && (recv != '1)) recv <= recv + 9'd1;
      case (fsm)
        IDLE: begin
          if (elig_a || elig_b) begin
            sel      <= pick;
            expected <= (pick == SEL_A) ? mem_used_a : mem_used_b;
            flush_a  <= (pick == SEL_A);
            flush_b  <= (pick == SEL_B);
            fsm      <= GRANT;
          end
        end
        GRANT: begin
          tmo  <= '0;
          recv <= '0;
          fsm  <= WAIT;
        end
        WAIT: begin
          if (flushing_sel) begin
            fsm <= RECV;
          end else if (tmo == TMO_W'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            last_served <= sel;
            fsm         <= IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        RECV: begin
          if (recv_done) begin
            if (recv != {1'b0, expected}) err_mismatch <= 1'b1;
            last_served <= sel;
            fsm         <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  // A simultaneous arrival and accept cancel; an arrival into a full buffer is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occupancy <= '0;
      overflow  <= 1'b0;
    end else if (unit_in && !accept) begin
      if (occupancy == CNT_W'(DEPTH)) overflow <= 1'b1;
      else                            occupancy <= occupancy + 1'b1;
    end else if (!unit_in && accept) begin
      occupancy <= occupancy - 1'b1;
    end
  end

`ifdef FLUSH_COLLECTOR_WAKE_EN
  localparam logic [2:0] ST_STBY  = 3'b001;
  localparam int         WAKE_DLY = 4;

  sel_t       wake_sel;
  logic [2:0] wake_cnt;
  logic [2:0] wake_state;

  assign wake_state = (wake_sel == SEL_A) ? state_a : state_b;

  // First pulse on drain completion, a second WAKE_DLY cycles later if the scanner sits in stby.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wake_sel    <= SEL_A;
      wake_cnt    <= '0;
      goto_stby_a <= 1'b0;
      goto_stby_b <= 1'b0;
    end else begin
      goto_stby_a <= 1'b0;
      goto_stby_b <= 1'b0;
      if (recv_done) begin
        wake_sel    <= sel;
        wake_cnt    <= 3'(WAKE_DLY);
        goto_stby_a <= (sel == SEL_A);
        goto_stby_b <= (sel == SEL_B);
      end else if (wake_cnt != '0) begin
        wake_cnt <= wake_cnt - 3'd1;
        if ((wake_cnt == 3'd1) && (wake_state == ST_STBY)) begin
          goto_stby_a <= (wake_sel == SEL_A);
          goto_stby_b <= (wake_sel == SEL_B);
        end
      end
    end
  end
`else
  assign goto_stby_a = 1'b0;
  assign goto_stby_b = 1'b0;
`endif

endmodule

// File: tb/tb_flush_collector.sv
// Self-checking bench for flush_collector: directed scenarios plus randomized requests checked
// against a transaction-level model of occupancy, round-robin order and sticky flags.
module tb_flush_collector;
  localparam int DEPTH = 512;
  localparam int CNT_W = 10;
  localparam logic [2:0] ST_STBY = 3'b001, ST_SCAN = 3'b010, ST_IDLE = 3'b011, ST_FLUSHING = 3'b100;

  logic             clk;
  logic             reset;
  logic [1:0]       rdy;
  logic [2:0]       st [2];
  logic [7:0]       mu [2];
  logic             flush_a, flush_b, goto_stby_a, goto_stby_b;
  logic             out_valid, out_ready, busy, err_timeout, err_mismatch, overflow;
  logic [CNT_W-1:0] occupancy;
  logic [1:0]       fl;

  int checks = 0;
  int errors = 0;
  // transaction-level reference model
  int m_occ, m_last;
  bit m_mis, m_ovf;

  assign fl = {flush_b, flush_a};

  flush_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .rdy_flush_a(rdy[0]), .rdy_flush_b(rdy[1]),
    .state_a(st[0]), .state_b(st[1]),
    .mem_used_a(mu[0]), .mem_used_b(mu[1]),
    .flush_a(flush_a), .flush_b(flush_b),
    .goto_stby_a(goto_stby_a), .goto_stby_b(goto_stby_b),
    .out_valid(out_valid), .out_ready(out_ready), .occupancy(occupancy),
    .busy(busy), .err_timeout(err_timeout), .err_mismatch(err_mismatch), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    rdy = 2'b00; out_ready = 1'b0;
    for (int s = 0; s < 2; s++) begin st[s] = ST_STBY; mu[s] = 8'd0; end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    step();
    m_occ = 0; m_last = 1; m_mis = 0; m_ovf = 0;
  endtask

  task automatic drop(input int s);
    rdy[s] = 1'b0;
    st[s]  = ST_STBY;
  endtask

  task automatic raise(input int s, input bit en, input int m);
    if (en) begin
      mu[s] = 8'(m);
      if ($urandom_range(0, 1) == 1) begin rdy[s] = 1'b1; st[s] = ST_SCAN; end
      else                           begin rdy[s] = 1'b0; st[s] = ST_IDLE; end
    end else begin
      drop(s);
      mu[s] = 8'($urandom_range(0, 100));
    end
  endtask

  task automatic expect_idle(input string tag, input int n);
    bit stray = 0;
    repeat (n) begin
      step();
      stray |= (fl != 2'b00) || busy;
    end
    check(tag, stray, 0);
  endtask

  // Waits for the grant to side s, enters flushing lat cycles after the pulse and presents
  // drain units counting down from flush_mem; out_ready is raised only on unit cycles if asked.
  task automatic serve(input int s, input int lat, input int flush_mem, input int drain,
                       input bit ready_on_units);
    int req_mem;
    bit got = 0;
    bit stray = 0;
    req_mem = int'(mu[s]);
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      got = (fl != 2'b00);
    end
    check("grant_seen", got, 1);
    check("grant_side", fl, (s == 0) ? 2'b01 : 2'b10);
    check("busy_in_grant", busy, 1);
    rdy[s] = 1'b0;
    step();
    check("flush_one_cycle", fl, 0);
    for (int i = 1; i < lat; i++) begin
      step();
      stray |= (fl != 2'b00);
    end
    st[s] = ST_FLUSHING;
    out_ready = ready_on_units;
    for (int k = 0; k < drain; k++) begin
      mu[s] = 8'(flush_mem - k);
      step();
      stray |= (fl != 2'b00);
    end
    st[s] = ST_STBY;
    mu[s] = 8'(flush_mem - drain);
    out_ready = 1'b0;
    step();
    check("no_flush_during_txn", stray, 0);
    if (!ready_on_units) m_occ += drain;
    if (m_occ > DEPTH) begin m_ovf = 1; m_occ = DEPTH; end
    if (drain != req_mem) m_mis = 1;
    m_last = s;
    check("busy_after_txn", busy, 0);
    check("occupancy", occupancy, m_occ);
    check("err_mismatch", err_mismatch, m_mis);
    check("overflow", overflow, m_ovf);
  endtask

  task automatic serve_rand(input int s);
    int m, d;
    m = int'(mu[s]);
    d = (m > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, m - 1) : m;
    serve(s, $urandom_range(1, 6), m, d, 0);
  endtask

  task automatic fill(input int s, input int m);
    rdy[s] = 1'b1; mu[s] = 8'(m); st[s] = ST_SCAN;
    serve(s, 1, m, m, 0);
  endtask

  initial begin
    bit got, stray;

    // reset state
    do_reset();
    check("rst_occupancy", occupancy, 0);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_flush", fl, 0);
    check("rst_goto_stby", {goto_stby_b, goto_stby_a}, 0);
    check("rst_errors", {err_timeout, err_mismatch, overflow}, 0);

    // single clean flush from A
    rdy[0] = 1'b1; mu[0] = 8'd85; st[0] = ST_SCAN;
    serve(0, 2, 85, 85, 0);
    check("out_valid_after_fill", out_valid, 1);

    // both request: A first after reset, B only after A completes
    do_reset();
    rdy = 2'b11; mu[0] = 8'd85; mu[1] = 8'd90; st[0] = ST_SCAN; st[1] = ST_SCAN;
    serve(0, 2, 85, 85, 0);
    serve(1, 3, 90, 90, 0);
    check("occupancy_175", occupancy, 175);

    // eligibility gated by free space
    do_reset();
    for (int i = 0; i < 4; i++) fill(0, 100);
    fill(0, 50);
    rdy[1] = 1'b1; mu[1] = 8'd90; st[1] = ST_SCAN;
    expect_idle("no_grant_62_free", 8);
    rdy[1] = 1'b0;
    out_ready = 1'b1;
    repeat (30) step();
    out_ready = 1'b0;
    m_occ -= 30;
    check("occupancy_420", occupancy, m_occ);
    rdy[1] = 1'b1;
    serve(1, 2, 90, 90, 0);
    fill(0, 2);
    check("occupancy_full", occupancy, DEPTH);

    // full buffer: arrival with accept holds occupancy, arrival without accept overflows
    rdy[0] = 1'b1; mu[0] = 8'd0; st[0] = ST_SCAN;
    serve(0, 2, 5, 5, 1);
    rdy[0] = 1'b1; mu[0] = 8'd0; st[0] = ST_SCAN;
    serve(0, 2, 3, 3, 0);

    // reset mid-transaction discards everything immediately
    rdy[1] = 1'b1; mu[1] = 8'd0; st[1] = ST_SCAN;
    step(); step();
    reset = 1'b0;
    #1;
    check("midrst_occupancy", occupancy, 0);
    check("midrst_busy", busy, 0);
    check("midrst_flush", fl, 0);
    check("midrst_sticky", {err_mismatch, overflow}, 0);

    // grant timeout, then round-robin resumes with B
    do_reset();
    rdy[0] = 1'b1; mu[0] = 8'd50; st[0] = ST_SCAN;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      got = (fl != 2'b00);
    end
    check("tmo_grant", fl, 2'b01);
    rdy[0] = 1'b0;
    stray = 0;
    repeat (16) begin
      step();
      stray |= err_timeout;
    end
    check("tmo_not_early", stray, 0);
    step();
    check("tmo_pulse", err_timeout, 1);
    check("tmo_idle", busy, 0);
    step();
    check("tmo_one_cycle", err_timeout, 0);
    m_last = 0;
    rdy = 2'b11; mu[0] = 8'd20; mu[1] = 8'd30; st[0] = ST_SCAN; st[1] = ST_SCAN;
    serve(1, 1, 30, 30, 0);
    serve(0, 4, 20, 20, 0);

    // short drain sets a sticky mismatch
    do_reset();
    rdy[0] = 1'b1; mu[0] = 8'd85; st[0] = ST_SCAN;
    serve(0, 2, 85, 80, 0);
    fill(1, 10);
    check("mismatch_sticky", err_mismatch, 1);

    // randomized requests against the model
    do_reset();
    for (int it = 0; it < 10; it++) begin
      int who, ma, mb, first, second, m2, k;
      bit ra, rb, ea, eb, r2;
      who = $urandom_range(0, 2);
      ra = (who != 1);
      rb = (who != 0);
      ma = $urandom_range(1, 100);
      mb = $urandom_range(1, 100);
      raise(0, ra, ma);
      raise(1, rb, mb);
      ea = ra && (ma <= DEPTH - m_occ);
      eb = rb && (mb <= DEPTH - m_occ);
      if (!ea && !eb) begin
        expect_idle("rand_no_grant", 6);
        drop(0);
        drop(1);
      end else begin
        first  = (ea && eb) ? 1 - m_last : (ea ? 0 : 1);
        second = 1 - first;
        r2     = (second == 0) ? ra : rb;
        m2     = (second == 0) ? ma : mb;
        serve_rand(first);
        if (r2) begin
          if (m2 <= DEPTH - m_occ) serve_rand(second);
          else begin
            expect_idle("rand_second_blocked", 6);
            drop(second);
          end
        end
      end
      k = $urandom_range(0, (m_occ > 60) ? 60 : m_occ);
      out_ready = 1'b1;
      repeat (k) step();
      out_ready = 1'b0;
      m_occ -= k;
      check("rand_occupancy_drain", occupancy, m_occ);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
